// File: rtl/mips_issue_pkg.sv
// Shared decode constants, field helpers and issue-stage state encoding.
// Imported by the ID issue stage, its hazard detector and the IF/ID interface.
package mips_issue_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SW       = 6'b101011;

    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } state_t;

    function automatic logic [5:0] f_opc(input logic [31:0] ins);
        return ins[OPC_LSB +: 6];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ins);
        return ins[RS_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ins);
        return ins[RT_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ins);
        return ins[RD_LSB +: 5];
    endfunction

endpackage

// File: rtl/id_issue_stage_if.sv
// IF <-> ID link: slot-sorted fetch packet toward ID, hazard/redirect back to IF.
// master = IF side (drives packet), slave = ID side (drives hazard/redirects).
import mips_issue_pkg::*;

interface id_issue_stage_if;
    logic [31:0] program_counter;
    logic [31:0] instruction_i;
    logic [31:0] instruction_j;
    logic [31:0] instruction_r;
    logic        type_i;
    logic        type_j;
    logic        type_r;
    logic        finish;
    logic        hazard;
    logic        PCSrc;
    logic [31:0] add_result;
    logic        jump;
    logic [31:0] jump_dir;

    modport master (
        output program_counter, instruction_i, instruction_j,
        output instruction_r, type_i, type_j, type_r, finish,
        input  hazard, PCSrc, add_result, jump, jump_dir
    );

    modport slave (
        input  program_counter, instruction_i, instruction_j,
        input  instruction_r, type_i, type_j, type_r, finish,
        output hazard, PCSrc, add_result, jump, jump_dir
    );
endinterface

// File: rtl/id_hazard_detect.sv
// Combinational hazard check of the ID packet against the ID/EX register.
// Ports: ID slot fields (i_id_*), ID/EX fields (i_ex_*), o_stall_len 0/1/2.
import mips_issue_pkg::*;

module id_hazard_detect (
    input  logic       i_id_typ_i,
    input  logic       i_id_typ_j,
    input  logic       i_id_typ_r,
    input  logic [5:0] i_id_opc_i,
    input  logic [4:0] i_id_rs_i,
    input  logic [4:0] i_id_rt_i,
    input  logic [5:0] i_id_opc_j,
    input  logic [4:0] i_id_rs_j,
    input  logic [4:0] i_id_rt_j,
    input  logic [4:0] i_id_rs_r,
    input  logic [4:0] i_id_rt_r,
    input  logic       i_ex_typ_i,
    input  logic [5:0] i_ex_opc_i,
    input  logic [4:0] i_ex_rt_i,
    input  logic       i_ex_typ_r,
    input  logic [5:0] i_ex_opc_r,
    input  logic [4:0] i_ex_rd_r,
    output logic [1:0] o_stall_len
);

    logic w_br;
    logic w_ld;
    logic w_alu;
    logic w_lu_i;
    logic w_lu_r;
    logic w_br_ld;
    logic w_br_alu;

    assign w_br = i_id_typ_j &&
        (i_id_opc_j == OP_BEQ || i_id_opc_j == OP_BNE);

    assign w_ld = i_ex_typ_i && i_ex_opc_i == OP_LW &&
        i_ex_rt_i != 5'd0;

    assign w_alu = i_ex_typ_r && i_ex_rd_r != 5'd0 &&
        (i_ex_opc_r == OP_RTYPE || i_ex_opc_r == OP_SPECIAL2);

    // i-slot rt is only read by a store; for loads it is the destination.
    assign w_lu_i = i_id_typ_i && (i_id_rs_i == i_ex_rt_i ||
        (i_id_opc_i == OP_SW && i_id_rt_i == i_ex_rt_i));

    assign w_lu_r = i_id_typ_r &&
        (i_id_rs_r == i_ex_rt_i || i_id_rt_r == i_ex_rt_i);

    assign w_br_ld = w_br && w_ld &&
        (i_id_rs_j == i_ex_rt_i || i_id_rt_j == i_ex_rt_i);

    assign w_br_alu = w_br && w_alu &&
        (i_id_rs_j == i_ex_rd_r || i_id_rt_j == i_ex_rd_r);

    always_comb begin
        o_stall_len = 2'd0;
        priority case (1'b1)
            w_br_ld: o_stall_len = 2'd2;
            (w_ld && (w_lu_i || w_lu_r)): o_stall_len = 2'd1;
            w_br_alu: o_stall_len = 2'd1;
            default: o_stall_len = 2'd0;
        endcase
    end

endmodule

// File: rtl/id_issue_stage.sv
// Dual-issue ID stage: IF/ID register, beq/bne/j resolution, stalls, ID/EX.
// Ports: clk, btnc_i (sync reset), fe (IF link), rf_*, ex_*, halted;
// ID_ISSUE_PERF_CNT_EN adds stall_count/flush_count.
import mips_issue_pkg::*;

module id_issue_stage #(
    parameter logic [31:0] HALT_PC = 32'h0000004C
) (
    input  logic        clk,
    input  logic        btnc_i,
    id_issue_stage_if.slave fe,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_ra2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    output logic [31:0] ex_instruction_i,
    output logic [31:0] ex_instruction_r,
    output logic        ex_type_i,
    output logic        ex_type_r,
    output logic [31:0] ex_pc,
    output logic        ex_valid,
`ifdef ID_ISSUE_PERF_CNT_EN
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
`endif
    output logic        halted
);

    logic [31:0] r_pc;
    logic [31:0] r_ins_i;
    logic [31:0] r_ins_j;
    logic [31:0] r_ins_r;
    logic        r_typ_i;
    logic        r_typ_j;
    logic        r_typ_r;
    logic        r_fin;

    logic [31:0] r_ex_ins_i;
    logic [31:0] r_ex_ins_r;
    logic        r_ex_typ_i;
    logic        r_ex_typ_r;
    logic [31:0] r_ex_pc;
    logic        r_ex_valid;

    state_t      r_state;
    state_t      w_nxt;
    logic [1:0]  r_stall_cnt;
    logic [1:0]  w_cnt_nxt;

    logic        w_pkt;
    logic        w_halt;
    logic [1:0]  w_len;
    logic [5:0]  w_opc_j;
    logic        w_is_br;
    logic        w_is_j;
    logic        w_taken;
    logic [31:0] w_p4;
    logic [31:0] w_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic        w_hazard;
    logic        w_pcsrc;
    logic        w_jump;
    logic        w_issue;
    logic        w_hold;

    assign w_pkt   = r_typ_i | r_typ_j | r_typ_r;
    assign w_halt  = !btnc_i && r_state != HALT &&
        ((w_pkt && r_pc == HALT_PC) || r_fin);

    assign w_opc_j = f_opc(r_ins_j);
    assign w_is_br = r_typ_j && (w_opc_j == OP_BEQ || w_opc_j == OP_BNE);
    assign w_is_j  = r_typ_j && w_opc_j == OP_J;
    assign w_taken = (w_opc_j == OP_BEQ) ? (rf_rd1 == rf_rd2)
                                         : (rf_rd1 != rf_rd2);

    assign w_p4     = r_pc + 32'd4;
    assign w_off    = {{14{r_ins_j[15]}}, r_ins_j[15:0], 2'b00};
    assign w_br_tgt = w_p4 + w_off;
    assign w_j_tgt  = {w_p4[31:28], r_ins_j[25:0], 2'b00};

    // Branch operands take the read ports; otherwise the i-slot does.
    assign rf_ra1 = w_is_br ? f_rs(r_ins_j) : f_rs(r_ins_i);
    assign rf_ra2 = w_is_br ? f_rt(r_ins_j) : f_rt(r_ins_i);

    id_hazard_detect u_haz (
        .i_id_typ_i (r_typ_i),
        .i_id_typ_j (r_typ_j),
        .i_id_typ_r (r_typ_r),
        .i_id_opc_i (f_opc(r_ins_i)),
        .i_id_rs_i  (f_rs(r_ins_i)),
        .i_id_rt_i  (f_rt(r_ins_i)),
        .i_id_opc_j (w_opc_j),
        .i_id_rs_j  (f_rs(r_ins_j)),
        .i_id_rt_j  (f_rt(r_ins_j)),
        .i_id_rs_r  (f_rs(r_ins_r)),
        .i_id_rt_r  (f_rt(r_ins_r)),
        .i_ex_typ_i (r_ex_typ_i),
        .i_ex_opc_i (f_opc(r_ex_ins_i)),
        .i_ex_rt_i  (f_rt(r_ex_ins_i)),
        .i_ex_typ_r (r_ex_typ_r),
        .i_ex_opc_r (f_opc(r_ex_ins_r)),
        .i_ex_rd_r  (f_rd(r_ex_ins_r)),
        .o_stall_len(w_len)
    );

    always_ff @(posedge clk) begin
        if (btnc_i) begin
            r_state     <= RUN;
            r_stall_cnt <= 2'd0;
        end else begin
            r_state     <= w_nxt;
            r_stall_cnt <= w_cnt_nxt;
        end
    end

    // The detecting RUN cycle is the first stall cycle; the counter
    // covers the remaining ones spent in STALL.
    always_comb begin
        w_nxt     = r_state;
        w_cnt_nxt = r_stall_cnt;
        w_hazard  = 1'b0;
        w_pcsrc   = 1'b0;
        w_jump    = 1'b0;
        w_issue   = 1'b0;
        if (!btnc_i) begin
            case (r_state)
                RUN: begin
                    if (w_halt) begin
                        w_nxt = HALT;
                    end else if (w_pkt && w_len != 2'd0) begin
                        w_hazard = 1'b1;
                        if (w_len == 2'd2) begin
                            w_nxt     = STALL;
                            w_cnt_nxt = 2'd1;
                        end
                    end else if (w_pkt) begin
                        w_pcsrc = w_is_br && w_taken;
                        w_jump  = w_is_j;
                        w_issue = !(w_is_br && w_taken) && !w_is_j;
                    end
                end
                STALL: begin
                    if (w_halt) begin
                        w_nxt = HALT;
                    end else begin
                        w_hazard  = 1'b1;
                        w_cnt_nxt = r_stall_cnt - 2'd1;
                        if (r_stall_cnt == 2'd1) begin
                            w_nxt = RUN;
                        end
                    end
                end
                HALT: begin
                    w_nxt = HALT;
                end
                default: begin
                    w_nxt = RUN;
                end
            endcase
        end
    end

    assign w_hold = w_hazard || r_state == HALT;

    always_ff @(posedge clk) begin
        if (btnc_i || w_pcsrc || w_jump) begin
            r_pc    <= 32'd0;
            r_ins_i <= 32'd0;
            r_ins_j <= 32'd0;
            r_ins_r <= 32'd0;
            r_typ_i <= 1'b0;
            r_typ_j <= 1'b0;
            r_typ_r <= 1'b0;
            r_fin   <= 1'b0;
        end else if (!w_hold) begin
            r_pc    <= fe.program_counter;
            r_ins_i <= fe.instruction_i;
            r_ins_j <= fe.instruction_j;
            r_ins_r <= fe.instruction_r;
            r_typ_i <= fe.type_i;
            r_typ_j <= fe.type_j;
            r_typ_r <= fe.type_r;
            r_fin   <= fe.finish;
        end
    end

    always_ff @(posedge clk) begin
        if (btnc_i || !w_issue) begin
            r_ex_ins_i <= 32'd0;
            r_ex_ins_r <= 32'd0;
            r_ex_typ_i <= 1'b0;
            r_ex_typ_r <= 1'b0;
            r_ex_pc    <= 32'd0;
            r_ex_valid <= 1'b0;
        end else begin
            r_ex_ins_i <= r_ins_i;
            r_ex_ins_r <= r_ins_r;
            r_ex_typ_i <= r_typ_i;
            r_ex_typ_r <= r_typ_r;
            r_ex_pc    <= r_pc;
            r_ex_valid <= 1'b1;
        end
    end

`ifdef ID_ISSUE_PERF_CNT_EN
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (btnc_i) begin
            r_stall_count <= 16'd0;
            r_flush_count <= 16'd0;
        end else if (r_state != HALT) begin
            if (w_hazard && r_stall_count != 16'hFFFF) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if ((w_pcsrc || w_jump) && r_flush_count != 16'hFFFF) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;
`endif

    assign fe.hazard     = w_hazard;
    assign fe.PCSrc      = w_pcsrc;
    assign fe.add_result = w_pcsrc ? w_br_tgt : 32'd0;
    assign fe.jump       = w_jump;
    assign fe.jump_dir   = w_jump ? w_j_tgt : 32'd0;

    assign ex_instruction_i = r_ex_ins_i;
    assign ex_instruction_r = r_ex_ins_r;
    assign ex_type_i        = r_ex_typ_i;
    assign ex_type_r        = r_ex_typ_r;
    assign ex_pc            = r_ex_pc;
    assign ex_valid         = r_ex_valid;
    assign halted           = r_state == HALT;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed self-checking bench for id_issue_stage.
// Walks reset, branches, jump, stalls and halt with hand-computed values.
module tb_id_issue_stage;

    logic        clk;
    logic        btnc_i;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] ex_instruction_i;
    logic [31:0] ex_instruction_r;
    logic        ex_type_i;
    logic        ex_type_r;
    logic [31:0] ex_pc;
    logic        ex_valid;
    logic        halted;
`ifdef ID_ISSUE_PERF_CNT_EN
    logic [15:0] stall_count;
    logic [15:0] flush_count;
`endif

    int n_chk;
    int n_err;

    id_issue_stage_if fe();

    id_issue_stage dut (
        .clk             (clk),
        .btnc_i          (btnc_i),
        .fe              (fe),
        .rf_ra1          (rf_ra1),
        .rf_ra2          (rf_ra2),
        .rf_rd1          (rf_rd1),
        .rf_rd2          (rf_rd2),
        .ex_instruction_i(ex_instruction_i),
        .ex_instruction_r(ex_instruction_r),
        .ex_type_i       (ex_type_i),
        .ex_type_r       (ex_type_r),
        .ex_pc           (ex_pc),
        .ex_valid        (ex_valid),
`ifdef ID_ISSUE_PERF_CNT_EN
        .stall_count     (stall_count),
        .flush_count     (flush_count),
`endif
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] e_r(input logic [4:0] rd,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
        return {6'h00, rs, rt, rd, 5'h00, 6'h20};
    endfunction

    function automatic logic [31:0] e_lw(input logic [4:0] rt,
                                         input logic [4:0] rs);
        return {6'h23, rs, rt, 16'h0000};
    endfunction

    function automatic logic [31:0] e_br(input logic [5:0] op,
                                         input logic [4:0] rs,
                                         input logic [4:0] rt,
                                         input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] e_j(input logic [25:0] idx);
        return {6'h02, idx};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [31:0] pc,
                       input logic [31:0] ii,
                       input logic [31:0] ij,
                       input logic [31:0] ir,
                       input logic ti, input logic tj,
                       input logic tr);
        fe.program_counter = pc;
        fe.instruction_i   = ii;
        fe.instruction_j   = ij;
        fe.instruction_r   = ir;
        fe.type_i          = ti;
        fe.type_j          = tj;
        fe.type_r          = tr;
    endtask

    task automatic idle();
        put(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        btnc_i = 1'b1;
        rf_rd1 = 32'd0;
        rf_rd2 = 32'd0;
        fe.finish = 1'b0;
        put(32'h0, 32'h0, 32'h0, e_r(10, 11, 12), 1'b0, 1'b0, 1'b1);

        tick(); tick(); #1;
        chk("rst_hazard", {31'd0, fe.hazard}, 32'd0);
        chk("rst_pcsrc", {31'd0, fe.PCSrc}, 32'd0);
        chk("rst_jump", {31'd0, fe.jump}, 32'd0);
        chk("rst_add", fe.add_result, 32'd0);
        chk("rst_jdir", fe.jump_dir, 32'd0);
        chk("rst_exv", {31'd0, ex_valid}, 32'd0);
        chk("rst_extr", {31'd0, ex_type_r}, 32'd0);
        chk("rst_halt", {31'd0, halted}, 32'd0);
        chk("rst_ra1", {27'd0, rf_ra1}, 32'd0);

        btnc_i = 1'b0;
        tick();
        chk("rel_exv", {31'd0, ex_valid}, 32'd0);
        idle();
        tick();
        chk("iss_exv", {31'd0, ex_valid}, 32'd1);
        chk("iss_extr", {31'd0, ex_type_r}, 32'd1);
        chk("iss_ins", ex_instruction_r, e_r(10, 11, 12));
        chk("iss_pc", ex_pc, 32'h0);

        put(32'h10, 32'h0, e_br(6'h04, 1, 2, 16'd3), 32'h0, 1'b0, 1'b1, 1'b0);
        rf_rd1 = 32'd5;
        rf_rd2 = 32'd5;
        tick();
        put(32'h14, 32'h0, 32'h0, e_r(9, 1, 2), 1'b0, 1'b0, 1'b1);
        #1;
        chk("beq_pcsrc", {31'd0, fe.PCSrc}, 32'd1);
        chk("beq_add", fe.add_result, 32'h20);
        chk("beq_jump", {31'd0, fe.jump}, 32'd0);
        chk("beq_haz", {31'd0, fe.hazard}, 32'd0);
        tick();
        idle();
        #1;
        chk("beq_exv", {31'd0, ex_valid}, 32'd0);
        chk("beq_pcsrc2", {31'd0, fe.PCSrc}, 32'd0);
        tick();
        chk("beq_flush", {31'd0, ex_type_r}, 32'd0);

        put(32'h10, 32'h0, e_br(6'h04, 1, 2, 16'd3), 32'h0, 1'b0, 1'b1, 1'b0);
        rf_rd2 = 32'd6;
        tick();
        idle();
        #1;
        chk("bnt_pcsrc", {31'd0, fe.PCSrc}, 32'd0);
        chk("bnt_haz", {31'd0, fe.hazard}, 32'd0);
        tick();
        chk("bnt_exv", {31'd0, ex_valid}, 32'd1);
        chk("bnt_pc", ex_pc, 32'h10);

        put(32'h08, 32'h0, e_j(26'h40), 32'h0, 1'b0, 1'b1, 1'b0);
        tick();
        put(32'h0C, 32'h0, 32'h0, e_r(9, 1, 2), 1'b0, 1'b0, 1'b1);
        #1;
        chk("j_jump", {31'd0, fe.jump}, 32'd1);
        chk("j_dir", fe.jump_dir, 32'h100);
        chk("j_pcsrc", {31'd0, fe.PCSrc}, 32'd0);
        tick();
        idle();
        #1;
        chk("j_jump2", {31'd0, fe.jump}, 32'd0);
        chk("j_exv", {31'd0, ex_valid}, 32'd0);
        tick();
        chk("j_flush", {31'd0, ex_valid}, 32'd0);

        put(32'h20, e_lw(3, 1), 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        put(32'h24, 32'h0, 32'h0, e_r(4, 3, 5), 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        #1;
        chk("lu_haz", {31'd0, fe.hazard}, 32'd1);
        chk("lu_exv", {31'd0, ex_valid}, 32'd1);
        chk("lu_exti", {31'd0, ex_type_i}, 32'd1);
        tick();
        #1;
        chk("lu_haz2", {31'd0, fe.hazard}, 32'd0);
        chk("lu_bub", {31'd0, ex_valid}, 32'd0);
        tick();
        chk("lu_exv2", {31'd0, ex_valid}, 32'd1);
        chk("lu_extr", {31'd0, ex_type_r}, 32'd1);
        chk("lu_ins", ex_instruction_r, e_r(4, 3, 5));
        chk("lu_pc", ex_pc, 32'h24);

        put(32'h30, e_lw(0, 1), 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        put(32'h34, 32'h0, 32'h0, e_r(4, 0, 5), 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        #1;
        chk("r0_haz", {31'd0, fe.hazard}, 32'd0);
        tick();
        chk("r0_exv", {31'd0, ex_valid}, 32'd1);
        chk("r0_pc", ex_pc, 32'h34);

        put(32'h40, 32'h0, 32'h0, e_r(6, 1, 2), 1'b0, 1'b0, 1'b1);
        tick();
        put(32'h44, 32'h0, e_br(6'h04, 6, 7, 16'd1), 32'h0, 1'b0, 1'b1, 1'b0);
        rf_rd1 = 32'd1;
        rf_rd2 = 32'd2;
        tick();
        idle();
        #1;
        chk("ab_haz", {31'd0, fe.hazard}, 32'd1);
        chk("ab_pcsrc", {31'd0, fe.PCSrc}, 32'd0);
        tick();
        rf_rd1 = 32'd8;
        rf_rd2 = 32'd8;
        #1;
        chk("ab_haz2", {31'd0, fe.hazard}, 32'd0);
        chk("ab_pcsrc2", {31'd0, fe.PCSrc}, 32'd1);
        chk("ab_add", fe.add_result, 32'h4C);
        chk("ab_exv", {31'd0, ex_valid}, 32'd0);
        tick();
        #1;
        chk("ab_exv2", {31'd0, ex_valid}, 32'd0);
        chk("ab_pcsrc3", {31'd0, fe.PCSrc}, 32'd0);

        put(32'h50, e_lw(7, 1), 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        put(32'h54, 32'h0, e_br(6'h05, 7, 1, 16'hFFFE), 32'h0,
            1'b0, 1'b1, 1'b0);
        rf_rd1 = 32'd3;
        rf_rd2 = 32'd4;
        tick();
        idle();
        #1;
        chk("lb_haz1", {31'd0, fe.hazard}, 32'd1);
        chk("lb_pcsrc1", {31'd0, fe.PCSrc}, 32'd0);
        tick();
        #1;
        chk("lb_haz2", {31'd0, fe.hazard}, 32'd1);
        chk("lb_exv2", {31'd0, ex_valid}, 32'd0);
        chk("lb_pcsrc2", {31'd0, fe.PCSrc}, 32'd0);
        tick();
        #1;
        chk("lb_haz3", {31'd0, fe.hazard}, 32'd0);
        chk("lb_pcsrc3", {31'd0, fe.PCSrc}, 32'd1);
        chk("lb_add", fe.add_result, 32'h50);
        tick();
        chk("lb_exv4", {31'd0, ex_valid}, 32'd0);

        put(32'h4C, 32'h0, 32'h0, e_r(9, 1, 2), 1'b0, 1'b0, 1'b1);
        tick();
        put(32'h50, 32'h0, 32'h0, e_r(9, 1, 2), 1'b0, 1'b0, 1'b1);
        #1;
        chk("h_pre", {31'd0, halted}, 32'd0);
        chk("h_haz", {31'd0, fe.hazard}, 32'd0);
        tick();
        chk("h_halt", {31'd0, halted}, 32'd1);
        chk("h_exv", {31'd0, ex_valid}, 32'd0);
        tick(); tick();
        #1;
        chk("h_halt2", {31'd0, halted}, 32'd1);
        chk("h_exv2", {31'd0, ex_valid}, 32'd0);
        chk("h_haz2", {31'd0, fe.hazard}, 32'd0);
`ifdef ID_ISSUE_PERF_CNT_EN
        chk("perf_stall", {16'd0, stall_count}, 32'd4);
        chk("perf_flush", {16'd0, flush_count}, 32'd4);
`endif

        btnc_i = 1'b1;
        tick();
        btnc_i = 1'b0;
        chk("rst2_halt", {31'd0, halted}, 32'd0);
`ifdef ID_ISSUE_PERF_CNT_EN
        chk("rst2_stall", {16'd0, stall_count}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
